// File: rtl/if_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_fetch
// Description : Instruction-fetch stage at the consumer end of the next-PC
//               interface. Owns the architectural PC, fetches the word at PC
//               from the instruction ROM over a req/ack handshake, holds it
//               for decode, and loads PC from npc once decode accepts.
//
// Ports       : cpu_clk     - system clock, rising edge
//               cpu_rst_n   - synchronous active-low reset
//               npc         - next PC from the next-PC calculator
//               npc_valid   - npc is valid this cycle
//               stall       - blocks acceptance of the held instruction
//               irom_req    - ROM fetch request (decoded from state)
//               irom_addr   - ROM fetch address (always equals pc)
//               irom_ack    - ROM read data valid this cycle
//               irom_rdata  - ROM read data
//               pc          - current PC
//               inst        - fetched instruction (registered)
//               inst_valid  - inst holds the instruction at pc (from state)
//               inst_ready  - decode accepts inst
//               misalign    - sticky: a misaligned npc was accepted
//               retired_cnt - count of accepted instructions (wraps)
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic [31:0]      npc,
    input  logic             npc_valid,
    input  logic             stall,
    output logic             irom_req,
    output logic [31:0]      irom_addr,
    input  logic             irom_ack,
    input  logic [31:0]      irom_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      inst,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic             misalign,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_valid = 2'd2;
    localparam logic [1:0] c_st_err   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic             r_misalign;
    logic [CNT_W-1:0] r_retired_cnt;

    // Acceptance of the held instruction; stall wins over ready/valid.
    logic w_accept;
    logic w_npc_aligned;
    logic w_ack_in_fetch;

    assign w_accept       = (r_state == c_st_valid) && inst_ready && npc_valid && !stall;
    assign w_npc_aligned  = (npc[1:0] == 2'b00);
    assign w_ack_in_fetch = (r_state == c_st_fetch) && irom_ack;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  w_state_nxt = c_st_fetch;
            c_st_fetch: if (irom_ack) w_state_nxt = c_st_valid;
            c_st_valid: if (w_accept) w_state_nxt = w_npc_aligned ? c_st_fetch : c_st_err;
            c_st_err:   w_state_nxt = c_st_err;   // left only through reset
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs: no input reaches these combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        irom_req   = 1'b0;
        inst_valid = 1'b0;
        case (r_state)
            c_st_fetch: irom_req   = 1'b1;
            c_st_valid: inst_valid = 1'b1;
            default: begin
                irom_req   = 1'b0;
                inst_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            r_pc          <= RESET_PC;
            r_inst        <= 32'h0000_0000;
            r_misalign    <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            if (w_ack_in_fetch) begin
                r_inst <= irom_rdata;
            end
            if (w_accept) begin
                if (w_npc_aligned) begin
                    r_pc          <= npc;
                    r_retired_cnt <= r_retired_cnt + 1'b1;
                end else begin
                    // pc and count stay put so the faulting context is visible.
                    r_misalign    <= 1'b1;
                end
            end
        end
    end

    assign irom_addr   = r_pc;
    assign pc          = r_pc;
    assign inst        = r_inst;
    assign misalign    = r_misalign;
    assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire
